// File: rtl/multu_seq_pkg.sv
// Shared definitions for the sequential multiplier: operand width, counter width helper
// and the idle/run phase type decoded from the busy flag.
package multu_seq_pkg;

  localparam int MUL_WIDTH = 32;

  // Two phases only; the phase is a view of the busy flag, never stored on its own.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_e;

  // Step counter width: enough bits to count WIDTH steps (0 .. WIDTH-1).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/multu_seq_mul_step.sv
// One add-and-shift step of the unsigned multiplier: conditionally add the multiplicand
// into hi, then shift carry:hi:lo right by one.
module multu_seq_mul_step
  import multu_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  assign w_addend = i_lo[0] ? {1'b0, i_mcand} : '0;
  assign w_sum    = {1'b0, i_hi} + w_addend;

  // The carry out of the add lands in hi's MSB; lo[0] has been consumed and drops out.
  assign {o_hi, o_lo} = {w_sum, i_lo[WIDTH-1:1]};

endmodule

// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// One product every WIDTH+1 cycles; hi/lo are only meaningful while busy is low.
module multu_seq
  import multu_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH-1:0] w_nxt_mcand;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic [CNT_W-1:0] w_nxt_count;
  logic             w_nxt_busy;
  logic             w_nxt_done;
  mul_state_e       w_state;

  multu_seq_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .i_mcand (r_mcand),
    .o_hi    (w_step_hi),
    .o_lo    (w_step_lo)
  );

  assign w_state = r_busy ? ST_RUN : ST_IDLE;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    w_nxt_mcand = r_mcand;
    w_nxt_hi    = r_hi;
    w_nxt_lo    = r_lo;
    w_nxt_count = r_count;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;

    unique case (w_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_mcand = multiplicand;
          w_nxt_hi    = '0;
          w_nxt_lo    = multiplier;
          w_nxt_count = '0;
          w_nxt_busy  = 1'b1;
        end
      end
      ST_RUN: begin
        // start and operand changes are ignored here: no queueing while iterating.
        w_nxt_hi    = w_step_hi;
        w_nxt_lo    = w_step_lo;
        w_nxt_count = r_count + CNT_W'(1);
        if (r_count == LAST) begin
          w_nxt_busy = 1'b0;
          w_nxt_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!reset) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_mcand <= w_nxt_mcand;
      r_hi    <= w_nxt_hi;
      r_lo    <= w_nxt_lo;
      r_count <= w_nxt_count;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed handshake/boundary cases plus random
// operands compared against a plain 64-bit multiplication.
module tb_multu_seq;

  localparam int W     = 32;
  localparam int LIMIT = 100;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;
  int done_seen;
  int completed;
  int cycles;

  multu_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] observed,
                       input logic [2*W-1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances until busy drops, bounded; returns the number of edges taken.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  // Launch, wait for completion, and compare against the reference product.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W-1:0] expected;
    int n;
    expected     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_launch"}, {63'd0, busy}, 64'd1);
    wait_idle(n);
    check({tag, "_cycles"}, 64'(n), 64'(W));
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_product"}, {hi, lo}, expected);
    completed++;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_checks     = 0;
    n_errors     = 0;
    done_seen    = 0;
    completed    = 0;
    reset        = 1'b0;
    start        = 1'b1;
    multiplicand = 32'd3;
    multiplier   = 32'd5;

    // 1: reset held low with start high for two edges; reset wins.
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_no_launch", {63'd0, busy}, 64'd0);

    // 2: basic product, then done must be a single-cycle pulse.
    run_op(32'd3, 32'd5, "a3b5");
    check("a3b5_hi", {32'd0, hi}, 64'd0);
    check("a3b5_lo", {32'd0, lo}, 64'd15);
    tick();
    check("done_pulse_width", {63'd0, done}, 64'd0);
    check("hold_after_done", {hi, lo}, 64'd15);

    // 3: all-ones operands exercise the carry into hi's MSB.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");
    check("ones_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("ones_lo", {32'd0, lo}, 64'd1);
    tick();

    // 4: MSB operand, then a back-to-back launch from the done cycle with a zero operand.
    run_op(32'h8000_0000, 32'd2, "msb");
    check("msb_hi", {32'd0, hi}, 64'd1);
    check("msb_lo", {32'd0, lo}, 64'd0);
    run_op(32'd0, 32'h1234_5678, "b2b_zero");
    tick();

    // 5a: operand changes and a start pulse mid-run are ignored.
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    multiplicand = 32'hDEAD_BEEF;
    multiplier   = 32'h0BAD_F00D;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(cycles);
    check("ignore_cycles", 64'(cycles + 10), 64'(W));
    check("ignore_done", {63'd0, done}, 64'd1);
    check("ignore_product", {hi, lo}, 64'd63);
    completed++;
    tick();
    check("ignore_no_relaunch", {63'd0, busy}, 64'd0);

    // 5b: reset at step 20 aborts with no done pulse.
    multiplicand = 32'h0001_0003;
    multiplier   = 32'h0000_0777;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    repeat (W + 4) tick();
    check("abort_stays_idle", {63'd0, busy}, 64'd0);
    check("abort_no_done", 64'(done_seen), 64'(completed));

    // 6: random operands with boundary values mixed in.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom();
      b = $urandom();
      case (i % 8)
        0: a = 32'd0;
        1: b = 32'd1;
        2: a = 32'hFFFF_FFFF;
        3: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        4: b = 32'd0;
        default: ;
      endcase
      run_op(a, b, "rand");
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
    check("done_count", 64'(done_seen), 64'(completed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
